// File: rtl/img_copy_engine.sv
// Copy engine: walks the source ROM and writes a copied, 2x-zoomed or 2x-decimated
// image into display memory, answering the control unit's start/done handshake.
module img_copy_engine #(
  parameter int unsigned SRC_W   = 320,
  parameter int unsigned SRC_H   = 240,
  parameter int unsigned DST_W   = 640,
  parameter int unsigned SRC_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_start,
  input  logic [1:0]  modo,
  input  logic [7:0]  src_data,
  output logic [16:0] src_addr,
  output logic [18:0] dest_addr,
  output logic [7:0]  dest_data,
  output logic        dest_wren,
  output logic        cpu_busy,
  output logic        cpu_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int unsigned DEPTH = SRC_LAT + 1;

  state_t      state;
  logic [1:0]  mode;
  logic [1:0]  drain_cnt;
  logic [9:0]  xd, yd;
  logic [9:0]  reg_w, reg_h;
  logic        last_x, last_y;
  logic [16:0] src_row, src_next;
  logic [16:0] x_step, row_step;
  logic [18:0] dest_row, dest_next;
  logic [DEPTH-1:0] vpipe;
  logic [18:0] dpipe [DEPTH];

  // Zoom repeats each source column/row twice: step the source only on odd xd / odd yd.
  always_comb begin
    reg_w    = 10'(SRC_W);
    reg_h    = 10'(SRC_H);
    x_step   = 17'd1;
    row_step = 17'(SRC_W);
    case (mode)
      2'd1: begin
        reg_w    = 10'(2 * SRC_W);
        reg_h    = 10'(2 * SRC_H);
        x_step   = {16'b0, xd[0]};
        row_step = yd[0] ? 17'(SRC_W) : '0;
      end
      2'd2: begin
        reg_w    = 10'(SRC_W / 2);
        reg_h    = 10'(SRC_H / 2);
        x_step   = 17'd2;
        row_step = 17'(2 * SRC_W);
      end
      default: ;
    endcase
    last_x = (xd == reg_w - 10'd1);
    last_y = (yd == reg_h - 10'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mode      <= '0;
      drain_cnt <= '0;
      xd        <= '0;
      yd        <= '0;
      src_row   <= '0;
      src_next  <= '0;
      dest_row  <= '0;
      dest_next <= '0;
      src_addr  <= '0;
      cpu_busy  <= 1'b0;
      cpu_done  <= 1'b0;
      vpipe     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) dpipe[i] <= '0;
    end else begin
      vpipe[0] <= 1'b0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vpipe[i] <= vpipe[i-1];
        dpipe[i] <= dpipe[i-1];
      end
      case (state)
        IDLE: begin
          if (cpu_start) begin
            state     <= RUN;
            mode      <= (modo == 2'd3) ? 2'd0 : modo;
            xd        <= '0;
            yd        <= '0;
            src_row   <= '0;
            src_next  <= '0;
            dest_row  <= '0;
            dest_next <= '0;
          end
        end
        RUN: begin
          src_addr <= src_next;
          vpipe[0] <= 1'b1;
          dpipe[0] <= dest_next;
          cpu_busy <= 1'b1;
          if (last_x) begin
            xd        <= '0;
            yd        <= yd + 10'd1;
            src_row   <= src_row + row_step;
            src_next  <= src_row + row_step;
            dest_row  <= dest_row + 19'(DST_W);
            dest_next <= dest_row + 19'(DST_W);
            if (last_y) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end else begin
            xd        <= xd + 10'd1;
            src_next  <= src_next + x_step;
            dest_next <= dest_next + 19'd1;
          end
        end
        // One extra count beyond the ROM latency lets the final write retire first.
        DRAIN: begin
          if (drain_cnt == 2'(SRC_LAT)) begin
            state    <= DONE;
            cpu_busy <= 1'b0;
            cpu_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        DONE: begin
          cpu_done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dest_wren = vpipe[SRC_LAT];
  assign dest_addr = dpipe[SRC_LAT];
  assign dest_data = dest_wren ? src_data : '0;

endmodule

// File: tb/tb_img_copy_engine.sv
// Directed bench for img_copy_engine on a reduced 8x6 source / 16-pixel-pitch geometry.
module tb_img_copy_engine;

  localparam int SW = 8;
  localparam int SH = 6;
  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_start = 1'b0;
  logic [1:0]  modo = 2'd0;
  logic [7:0]  src_data;
  logic [16:0] src_addr;
  logic [18:0] dest_addr;
  logic [7:0]  dest_data;
  logic        dest_wren, cpu_busy, cpu_done;

  logic [7:0]  zero8 = 8'h00;
  logic [16:0] a1_src, a3_src;
  logic [18:0] a1_dst, a3_dst;
  logic [7:0]  a1_dd, a3_dd;
  logic        a1_wr, a3_wr, a1_busy, a3_busy, a1_done, a3_done;

  always #5 clk = ~clk;

  img_copy_engine #(.SRC_W(SW), .SRC_H(SH), .DST_W(DW), .SRC_LAT(2)) dut (
    .clk(clk), .reset(reset), .cpu_start(cpu_start), .modo(modo), .src_data(src_data),
    .src_addr(src_addr), .dest_addr(dest_addr), .dest_data(dest_data), .dest_wren(dest_wren),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done));

  img_copy_engine #(.SRC_W(SW), .SRC_H(SH), .DST_W(DW), .SRC_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset), .cpu_start(cpu_start), .modo(modo), .src_data(zero8),
    .src_addr(a1_src), .dest_addr(a1_dst), .dest_data(a1_dd), .dest_wren(a1_wr),
    .cpu_busy(a1_busy), .cpu_done(a1_done));

  img_copy_engine #(.SRC_W(SW), .SRC_H(SH), .DST_W(DW), .SRC_LAT(3)) dut_l3 (
    .clk(clk), .reset(reset), .cpu_start(cpu_start), .modo(modo), .src_data(zero8),
    .src_addr(a3_src), .dest_addr(a3_dst), .dest_data(a3_dd), .dest_wren(a3_wr),
    .cpu_busy(a3_busy), .cpu_done(a3_done));

  function automatic logic [7:0] rom_f(input logic [16:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Two-cycle ROM model for the main instance
  logic [16:0] ra1 = '0, ra2 = '0;
  always @(posedge clk) begin
    ra1 <= src_addr;
    ra2 <= ra1;
  end
  assign src_data = rom_f(ra2);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [18:0] wa[$];
  logic [7:0]  wd[$];
  int done_cnt = 0, done_at = 0, first_wr = 0, last_wr = 0;
  int d1_at = 0, d3_at = 0, a1_cnt = 0, a3_cnt = 0;

  always @(negedge clk) begin
    if (dest_wren) begin
      if (wa.size() == 0) first_wr = cyc;
      last_wr = cyc;
      wa.push_back(dest_addr);
      wd.push_back(dest_data);
    end
    if (cpu_done) begin
      done_cnt++;
      done_at = cyc;
    end
    if (a1_done) d1_at = cyc;
    if (a3_done) d3_at = cyc;
    if (a1_wr) a1_cnt++;
    if (a3_wr) a3_cnt++;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  task automatic start_xfer(input logic [1:0] m, output int t0);
    step();
    cpu_start = 1'b1;
    modo = m;
    step();
    cpu_start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int prev, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (done_cnt > prev) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    n_cmp++; if (src_addr !== 17'd0)  begin n_bad++; $display("FAIL reset_src_addr got %0d want 0", src_addr); end
    n_cmp++; if (dest_addr !== 19'd0) begin n_bad++; $display("FAIL reset_dest_addr got %0d want 0", dest_addr); end
    n_cmp++; if (dest_data !== 8'd0)  begin n_bad++; $display("FAIL reset_dest_data got %0h want 0", dest_data); end
    n_cmp++; if (dest_wren !== 1'b0)  begin n_bad++; $display("FAIL reset_dest_wren got %b want 0", dest_wren); end
    n_cmp++; if (cpu_busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy got %b want 0", cpu_busy); end
    n_cmp++; if (cpu_done !== 1'b0)   begin n_bad++; $display("FAIL reset_done got %b want 0", cpu_done); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_copy();
    int t0, prev, bad;
    bit ok;
    clear_log();
    prev = done_cnt;
    start_xfer(2'd0, t0);
    n_cmp++; if (cpu_busy !== 1'b0) begin n_bad++; $display("FAIL copy_busy_T got %b want 0", cpu_busy); end
    step();
    n_cmp++; if (cpu_busy !== 1'b1) begin n_bad++; $display("FAIL copy_busy_T1 got %b want 1", cpu_busy); end
    wait_done(prev, 200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL copy_done_timeout got none want pulse"); end
    n_cmp++; if (cpu_busy !== 1'b0) begin n_bad++; $display("FAIL copy_busy_at_done got %b want 0", cpu_busy); end
    n_cmp++; if (done_at - t0 !== 51) begin n_bad++; $display("FAIL copy_done_delay got %0d want 51", done_at - t0); end
    n_cmp++; if (wa.size() !== 48) begin n_bad++; $display("FAIL copy_count got %0d want 48", wa.size()); end
    n_cmp++; if (first_wr - t0 !== 3) begin n_bad++; $display("FAIL copy_first_wr got %0d want 3", first_wr - t0); end
    n_cmp++; if (last_wr - first_wr !== 47) begin n_bad++; $display("FAIL copy_wr_span got %0d want 47", last_wr - first_wr); end
    if (wa.size() == 48) begin
      n_cmp++; if (wa[0] !== 19'd0 || wd[0] !== 8'h5A) begin n_bad++; $display("FAIL copy_first got %0d/%h want 0/5a", wa[0], wd[0]); end
      n_cmp++; if (wa[7] !== 19'd7 || wd[7] !== 8'h5D) begin n_bad++; $display("FAIL copy_row_end got %0d/%h want 7/5d", wa[7], wd[7]); end
      n_cmp++; if (wa[47] !== 19'd87 || wd[47] !== 8'h75) begin n_bad++; $display("FAIL copy_last got %0d/%h want 87/75", wa[47], wd[47]); end
      bad = 0;
      for (int i = 0; i < 48; i++)
        if (wa[i] !== 19'((i / SW) * DW + i % SW) || wd[i] !== rom_f(17'(i))) bad++;
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL copy_image got %0d bad pixels want 0", bad); end
    end
  endtask

  task automatic test_zoom();
    int t0, prev, bad, four;
    int hist[256];
    bit ok;
    clear_log();
    prev = done_cnt;
    start_xfer(2'd1, t0);
    wait_done(prev, 400, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL zoom_done_timeout got none want pulse"); end
    n_cmp++; if (done_at - t0 !== 195) begin n_bad++; $display("FAIL zoom_done_delay got %0d want 195", done_at - t0); end
    n_cmp++; if (wa.size() !== 192) begin n_bad++; $display("FAIL zoom_count got %0d want 192", wa.size()); end
    if (wa.size() == 192) begin
      n_cmp++; if (wa[17] !== 19'd17 || wd[17] !== 8'h5A) begin n_bad++; $display("FAIL zoom_17 got %0d/%h want 17/5a", wa[17], wd[17]); end
      n_cmp++; if (wa[191] !== 19'd191 || wd[191] !== 8'h75) begin n_bad++; $display("FAIL zoom_last got %0d/%h want 191/75", wa[191], wd[191]); end
      bad = 0;
      foreach (hist[k]) hist[k] = 0;
      for (int i = 0; i < 192; i++) begin
        hist[wd[i]]++;
        if (wa[i] !== 19'(i) || wd[i] !== rom_f(17'(((i / 16) / 2) * SW + (i % 16) / 2))) bad++;
      end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL zoom_image got %0d bad pixels want 0", bad); end
      four = 0;
      for (int s = 0; s < 48; s++) if (hist[rom_f(17'(s))] == 4) four++;
      n_cmp++; if (four != 48) begin n_bad++; $display("FAIL zoom_x4 got %0d sources seen 4x want 48", four); end
    end
  endtask

  task automatic test_decimate();
    int t0, prev, bad;
    bit ok;
    clear_log();
    prev = done_cnt;
    start_xfer(2'd2, t0);
    wait_done(prev, 100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL dec_done_timeout got none want pulse"); end
    n_cmp++; if (done_at - t0 !== 15) begin n_bad++; $display("FAIL dec_done_delay got %0d want 15", done_at - t0); end
    n_cmp++; if (wa.size() !== 12) begin n_bad++; $display("FAIL dec_count got %0d want 12", wa.size()); end
    if (wa.size() == 12) begin
      n_cmp++; if (wa[1] !== 19'd1 || wd[1] !== 8'h58) begin n_bad++; $display("FAIL dec_1 got %0d/%h want 1/58", wa[1], wd[1]); end
      n_cmp++; if (wa[11] !== 19'd35 || wd[11] !== 8'h7C) begin n_bad++; $display("FAIL dec_last got %0d/%h want 35/7c", wa[11], wd[11]); end
      bad = 0;
      for (int i = 0; i < 12; i++)
        if (wa[i] !== 19'((i / 4) * DW + i % 4) || wd[i] !== rom_f(17'((i / 4) * 2 * SW + (i % 4) * 2))) bad++;
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL dec_image got %0d bad pixels want 0", bad); end
    end
  endtask

  task automatic test_handshake();
    int t0, prev, bad;
    bit ok;
    clear_log();
    prev = done_cnt;
    start_xfer(2'd0, t0);
    for (int i = 0; i < 10; i++) step();
    cpu_start = 1'b1;
    modo = 2'd1;
    step();
    cpu_start = 1'b0;
    step();
    modo = 2'd2;
    wait_done(prev, 200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL hs_done_timeout got none want pulse"); end
    n_cmp++; if (done_at - t0 !== 51) begin n_bad++; $display("FAIL hs_done_delay got %0d want 51", done_at - t0); end
    n_cmp++; if (wa.size() !== 48) begin n_bad++; $display("FAIL hs_count got %0d want 48", wa.size()); end
    if (wa.size() == 48) begin
      bad = 0;
      for (int i = 0; i < 48; i++)
        if (wa[i] !== 19'((i / SW) * DW + i % SW) || wd[i] !== rom_f(17'(i))) bad++;
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL hs_image got %0d bad pixels want 0", bad); end
    end
    for (int i = 0; i < 5; i++) step();
    n_cmp++; if (done_cnt - prev !== 1) begin n_bad++; $display("FAIL hs_single_done got %0d want 1", done_cnt - prev); end
    n_cmp++; if (cpu_busy !== 1'b0) begin n_bad++; $display("FAIL hs_idle_busy got %b want 0", cpu_busy); end
  endtask

  task automatic test_back_to_back();
    int t0, prev;
    bit ok;
    prev = done_cnt;
    start_xfer(2'd2, t0);
    wait_done(prev, 100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_first_timeout got none want pulse"); end
    // Start asserted in the done cycle and held into the following cycle
    clear_log();
    prev = done_cnt;
    cpu_start = 1'b1;
    modo = 2'd2;
    step();
    n_cmp++; if (cpu_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_after_done got %b want 0", cpu_busy); end
    step();
    cpu_start = 1'b0;
    t0 = cyc;
    n_cmp++; if (cpu_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_T got %b want 0", cpu_busy); end
    step();
    n_cmp++; if (cpu_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_T1 got %b want 1", cpu_busy); end
    wait_done(prev, 100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_second_timeout got none want pulse"); end
    n_cmp++; if (done_at - t0 !== 15) begin n_bad++; $display("FAIL b2b_done_delay got %0d want 15", done_at - t0); end
    n_cmp++; if (wa.size() !== 12) begin n_bad++; $display("FAIL b2b_count got %0d want 12", wa.size()); end
  endtask

  task automatic test_reset_mid();
    int t0, prev, guard;
    bit ok;
    clear_log();
    start_xfer(2'd1, t0);
    guard = 0;
    while (wa.size() < 10 && guard < 100) begin step(); guard++; end
    n_cmp++; if (wa.size() < 10) begin n_bad++; $display("FAIL rst_mid_reach got %0d writes want 10", wa.size()); end
    prev = done_cnt;
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (src_addr !== 17'd0)  begin n_bad++; $display("FAIL rst_mid_src_addr got %0d want 0", src_addr); end
    n_cmp++; if (dest_addr !== 19'd0) begin n_bad++; $display("FAIL rst_mid_dest_addr got %0d want 0", dest_addr); end
    n_cmp++; if (dest_data !== 8'd0)  begin n_bad++; $display("FAIL rst_mid_dest_data got %0h want 0", dest_data); end
    n_cmp++; if (dest_wren !== 1'b0)  begin n_bad++; $display("FAIL rst_mid_wren got %b want 0", dest_wren); end
    n_cmp++; if (cpu_busy !== 1'b0)   begin n_bad++; $display("FAIL rst_mid_busy got %b want 0", cpu_busy); end
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    for (int i = 0; i < 200; i++) step();
    n_cmp++; if (done_cnt !== prev) begin n_bad++; $display("FAIL rst_mid_no_done got %0d want %0d", done_cnt, prev); end
    n_cmp++; if (cpu_busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_idle got %b want 0", cpu_busy); end
    clear_log();
    start_xfer(2'd0, t0);
    wait_done(prev, 200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_fresh_timeout got none want pulse"); end
    n_cmp++; if (done_at - t0 !== 51) begin n_bad++; $display("FAIL rst_fresh_delay got %0d want 51", done_at - t0); end
    n_cmp++; if (wa.size() !== 48) begin n_bad++; $display("FAIL rst_fresh_count got %0d want 48", wa.size()); end
  endtask

  task automatic test_mode3();
    int t0, prev, bad;
    bit ok;
    for (int i = 0; i < 6; i++) step();
    clear_log();
    a1_cnt = 0;
    a3_cnt = 0;
    prev = done_cnt;
    start_xfer(2'd3, t0);
    wait_done(prev, 200, ok);
    for (int i = 0; i < 3; i++) step();
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL m3_done_timeout got none want pulse"); end
    n_cmp++; if (done_at - t0 !== 51) begin n_bad++; $display("FAIL m3_l2_delay got %0d want 51", done_at - t0); end
    n_cmp++; if (d1_at - t0 !== 50) begin n_bad++; $display("FAIL m3_l1_delay got %0d want 50", d1_at - t0); end
    n_cmp++; if (d3_at - t0 !== 52) begin n_bad++; $display("FAIL m3_l3_delay got %0d want 52", d3_at - t0); end
    n_cmp++; if (a1_cnt !== 48) begin n_bad++; $display("FAIL m3_l1_count got %0d want 48", a1_cnt); end
    n_cmp++; if (a3_cnt !== 48) begin n_bad++; $display("FAIL m3_l3_count got %0d want 48", a3_cnt); end
    n_cmp++; if (wa.size() !== 48) begin n_bad++; $display("FAIL m3_count got %0d want 48", wa.size()); end
    if (wa.size() == 48) begin
      bad = 0;
      for (int i = 0; i < 48; i++)
        if (wa[i] !== 19'((i / SW) * DW + i % SW) || wd[i] !== rom_f(17'(i))) bad++;
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL m3_image got %0d bad pixels want 0", bad); end
    end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_zoom();
    test_decimate();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_mode3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/img_copy_engine.md
# img_copy_engine

Copy engine that answers the control unit's `cpu_start`/`cpu_done` handshake. It walks the 320x240 source ROM and writes the transformed image into the 640x480 display memory through the control unit's `src_addr_from_cpu` / `dest_addr_from_cpu` / `data_from_cpu` / `wren_from_cpu` path. Three transforms are supported: direct copy, 2x nearest-neighbour zoom and 2x decimation. The block runs in the 25 MHz domain, alongside the VGA controller and the control unit.

## Interface
Parameters:
- `SRC_W`, 320, source width in pixels
- `SRC_H`, 240, source height in pixels
- `DST_W`, 640, destination row pitch in pixels
- `SRC_LAT`, 2, source ROM read latency in cycles (1..3)

Ports. One clock; reset is asynchronous and active-low:
- `clk`  in  1  25 MHz clock
- `reset`  in  1  asynchronous, active-low reset
- `cpu_start`  in  1  start request, level-sampled in IDLE
- `modo`  in  2  transform: 0 copy, 1 zoom 2x, 2 decimate 2x, 3 treated as 0
- `src_data`  in  8  source ROM output
- `src_addr`  out  17  source ROM address
- `dest_addr`  out  19  display memory address
- `dest_data`  out  8  write data
- `dest_wren`  out  1  display memory write enable
- `cpu_busy`  out  1  high while a transfer is in progress
- `cpu_done`  out  1  one-cycle completion pulse

## Operation
States and transitions:
- IDLE: sample `cpu_start`. If high, latch `modo` and go to RUN.
- RUN: issue one source read per cycle, walking the destination region raster-order (x fastest). After the last read, go to DRAIN.
- DRAIN: wait `SRC_LAT` cycles for the pipeline to empty, then go to DONE.
- DONE: pulse `cpu_done` for one cycle and return to IDLE.

Destination region per latched mode, with destination coordinate (xd, yd) and source coordinate (xs, ys):
- Mode 0 (copy): region is 320x240 at top-left; xs=xd, ys=yd; 76800 writes.
- Mode 1 (zoom): region is 640x480; xs=xd>>1, ys=yd>>1; 307200 writes.
- Mode 2 (decimate): region is 160x120 at top-left; xs=xd<<1, ys=yd<<1; 19200 writes.
- Mode 3: identical to mode 0.
- Destination pixels outside the region are never written.

Address arithmetic:
- `src_addr` = ys*SRC_W+xs; `dest_addr` = yd*DST_W+xd.
- Both addresses come from incrementally updated row-base registers. No multipliers.
- Results fit exactly in 17 and 19 bits; there is no overflow or wrap in any mode.
- Counters wrap xd to 0 at the region width and increment yd. The last pixel ends RUN; there is no wrap past it.

Pipeline:
- `dest_addr` is delayed `SRC_LAT` cycles to align with `src_data`.
- `dest_data` = `src_data` in the write cycle.

Control rules:
- `cpu_start` is ignored outside IDLE.
- A change of `modo` during a transfer has no effect, because the mode was latched at start.
- Reset mid-transfer aborts immediately: all outputs 0, state IDLE, no `cpu_done`. The partially written image stays in memory.

## Timing
- Reset values: `src_addr` 0, `dest_addr` 0, `dest_data` 0, `dest_wren` 0, `cpu_busy` 0, `cpu_done` 0.
- Cycle numbering: `cpu_start` is sampled high at edge T; N = write count, L = `SRC_LAT`.
- `cpu_busy` rises at T+1 and stays high through T+L+N.
- First `src_addr` is presented at T+1; read k (0-based) is presented at T+1+k.
- `dest_wren` is high for exactly N consecutive cycles, T+1+L .. T+L+N, with no bubbles.
- `cpu_done` is high for the single cycle T+L+N+1. `cpu_busy` is 0 in that cycle.
- Back-to-back transfers: the earliest accepted restart is `cpu_start` sampled in the cycle after `cpu_done`. `cpu_start` held high during DONE is not accepted until IDLE.
- When not writing, `dest_wren` is 0. `dest_addr` and `dest_data` may hold stale values.

## Test plan
- Mode 0, ROM pattern = address[7:0], L=2:
  - Exactly 76800 writes.
  - First write: `dest_addr` 0, data 0.
  - Write for (319,0): `dest_addr` 319, data 0x3F.
  - Last write: `dest_addr` 239*640+319 = 153279, data from src 76799 (0xFF).
  - `cpu_done` 76803 cycles after start.
- Mode 1:
  - 307200 writes.
  - `dest_addr` 641 carries src 0.
  - `dest_addr` 307199 carries src 76799.
  - Each source value appears 4 times.
- Mode 2:
  - 19200 writes.
  - `dest_addr` 1 carries src 2.
  - Last `dest_addr` 119*640+159 = 76319 carries src 238*320+318 = 76478.
- Handshake:
  - Pulse `cpu_start` during RUN and toggle `modo`: write count and addresses are unchanged.
  - `cpu_start` the cycle after `cpu_done` is accepted; `cpu_busy` rises next edge.
- Reset mid-transfer:
  - Assert `reset`=0 at write 1000 of mode 1: all outputs 0 asynchronously, no `cpu_done`.
  - After release, a fresh start completes normally.
- Mode 3 with L=1 and L=3: behaves as mode 0; `cpu_done` is at start+76802 and start+76804 cycles respectively.
